// File: rtl/iob_eth_dmamem_if.sv
// Bus bundle for the Ethernet DMA packet buffer.
// Holds the MAC-side d_* responder port and the CPU-side c_* port.
interface iob_eth_dmamem_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_ADDR_W = 11
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic                  d_valid;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [STRB_W-1:0]     d_wstrb;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_ready;
    logic                  d_err;

    logic                  c_valid;
    logic [MEM_ADDR_W+1:0] c_address;
    logic [DATA_W-1:0]     c_wdata;
    logic [STRB_W-1:0]     c_wstrb;
    logic [DATA_W-1:0]     c_rdata;
    logic                  c_ready;

    modport master (
        output d_valid, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_ready, d_err,
        output c_valid, c_address, c_wdata, c_wstrb,
        input  c_rdata, c_ready
    );

    modport slave (
        input  d_valid, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_ready, d_err,
        input  c_valid, c_address, c_wdata, c_wstrb,
        output c_rdata, c_ready
    );
endinterface

// File: rtl/iob_eth_dmamem.sv
// Dual-port Ethernet packet buffer: MAC DMA responder with window check and
// optional wait states, plus a 1-cycle pipelined CPU port.
module iob_eth_dmamem #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       MEM_ADDR_W  = 11,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    iob_eth_dmamem_if.slave bus,
    output logic [7:0]      oob_cnt
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned DEPTH  = 1 << MEM_ADDR_W;
    localparam int unsigned IDX_W  = MEM_ADDR_W;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_range_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              d_ready_q, d_ready_d;
    logic              d_err_q, d_err_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [7:0]        oob_cnt_q, oob_cnt_d;
    logic              c_ready_q;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;

    // Window decode of the live DMA address; borrow bit flags d_addr < BASE_ADDR
    logic [ADDR_W:0]   req_diff_c;
    logic              req_in_range_c;
    logic [IDX_W-1:0]  req_idx_c;
    logic [IDX_W-1:0]  c_idx_c;
    logic              unused_c;

    assign req_diff_c     = {1'b0, bus.d_addr} - {1'b0, BASE_ADDR};
    assign req_in_range_c = !req_diff_c[ADDR_W] && (req_diff_c[ADDR_W-1:IDX_W+2] == '0);
    assign req_idx_c      = req_diff_c[IDX_W+1:2];
    assign c_idx_c        = bus.c_address[IDX_W+1:2];
    assign unused_c       = ^{req_diff_c[1:0], bus.c_address[1:0]};

    logic              sel_in_range_c;
    logic              sel_is_read_c;
    logic [IDX_W-1:0]  sel_idx_c;
    logic              cpu_we_c;
    logic              dma_we_c;

    // In IDLE the response is built from the live request, later from the latched one
    assign sel_in_range_c = (state_q == S_IDLE) ? req_in_range_c : in_range_q;
    assign sel_is_read_c  = (state_q == S_IDLE) ? (bus.d_wstrb == '0) : (wstrb_q == '0);
    assign sel_idx_c      = (state_q == S_IDLE) ? req_idx_c : idx_q;
    assign cpu_we_c       = !rst && bus.c_valid && (bus.c_wstrb != '0);
    assign dma_we_c       = !rst && (state_q == S_RESP) && in_range_q && (wstrb_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        if ((state_q == S_IDLE) && bus.d_valid) begin
            in_range_q <= req_in_range_c;
            idx_q      <= req_idx_c;
            wdata_q    <= bus.d_wdata;
            wstrb_q    <= bus.d_wstrb;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.d_valid) begin
                    if (WAIT_CYCLES != 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        d_ready_d = (state_d == S_RESP);
        d_err_d   = (state_d == S_RESP) && !sel_in_range_c;
        d_rdata_d = '0;
        if ((state_d == S_RESP) && sel_in_range_c && sel_is_read_c) d_rdata_d = mem[sel_idx_c];
        oob_cnt_d = oob_cnt_q;
        if ((state_q == S_RESP) && !in_range_q && (oob_cnt_q != 8'hFF)) oob_cnt_d = oob_cnt_q + 8'd1;
        c_rdata_d = c_rdata_q;
        if (bus.c_valid && (bus.c_wstrb == '0)) c_rdata_d = mem[c_idx_c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_ready_q <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= '0;
            oob_cnt_q <= '0;
            c_ready_q <= 1'b0;
            c_rdata_q <= '0;
        end else begin
            d_ready_q <= d_ready_d;
            d_err_q   <= d_err_d;
            d_rdata_q <= d_rdata_d;
            oob_cnt_q <= oob_cnt_d;
            c_ready_q <= bus.c_valid;
            c_rdata_q <= c_rdata_d;
        end
    end

    // DMA bytes are written last so they win a same-word, same-byte collision
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (cpu_we_c && bus.c_wstrb[b]) mem[c_idx_c][b*8 +: 8] <= bus.c_wdata[b*8 +: 8];
            if (dma_we_c && wstrb_q[b])     mem[idx_q][b*8 +: 8]   <= wdata_q[b*8 +: 8];
        end
    end

    assign bus.d_ready = d_ready_q;
    assign bus.d_err   = d_err_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.c_ready = c_ready_q;
    assign bus.c_rdata = c_rdata_q;
    assign oob_cnt     = oob_cnt_q;
endmodule
